// File: rtl/watch_cu_set.sv
// watch_cu_set: RUN/SET control unit for the watch datapath.
// Handles field select, adjust pulses, hold-to-repeat, clear, inactivity timeout and blink.
module watch_cu_set #(
    parameter int N_FIELDS       = 3,
    parameter int SEL_W          = 2,
    parameter int CNT_W          = 32,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int BLINK_CYCLES   = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                i_btn_mode,
    input  logic                i_btn_next,
    input  logic                i_btn_up,
    input  logic                i_btn_down,
    output logic                o_run,
    output logic                o_clear,
    output logic                o_set_mode,
    output logic [SEL_W-1:0]    o_sel,
    output logic [N_FIELDS-1:0] o_add,
    output logic [N_FIELDS-1:0] o_sub,
    output logic                o_blink
);
    typedef enum logic {RUN, SET} state_t;
    state_t state, state_d;
    logic [SEL_W-1:0] sel_d;
    logic [N_FIELDS-1:0] add_d, sub_d, onehot;
    logic clear_d, blink_d, rep_phase, rep_phase_d, rep_fire, held, quiet;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_d, to_cnt, to_cnt_d, blink_cnt, blink_cnt_d, rep_lim;
    logic [3:0] hist, btn, press;

    assign btn = {i_btn_mode, i_btn_next, i_btn_up, i_btn_down};
    assign press = btn & ~hist;
    assign held = i_btn_up ^ i_btn_down;
    assign quiet = ~|press[1:0];
    assign onehot = N_FIELDS'(1) << o_sel;
    assign o_set_mode = (state == SET);
    assign o_run = ~o_set_mode;

    always_comb begin
        state_d = state;
        sel_d = o_sel;
        add_d = '0;
        sub_d = '0;
        clear_d = 1'b0;
        blink_d = 1'b0;
        rep_cnt_d = '0;
        rep_phase_d = 1'b0;
        to_cnt_d = '0;
        blink_cnt_d = '0;
        rep_fire = 1'b0;
        rep_lim = rep_phase ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES);
        if (!cs) begin
            state_d = RUN;
            sel_d = '0;
        end else if (state == RUN) begin
            if (press[3]) begin
                state_d = SET;
                sel_d = '0;
                blink_d = 1'b1;
            end
        end else if (press[3]) begin
            state_d = RUN;
            sel_d = '0;
        end else begin
            // Repeat timer only runs while exactly one of up/down is held with no fresh press
            rep_fire = held && quiet && (rep_cnt + 1'b1 == rep_lim);
            if (held && quiet) begin
                rep_cnt_d = rep_fire ? '0 : rep_cnt + 1'b1;
                rep_phase_d = rep_phase | rep_fire;
            end
            add_d = ((press[1] & ~press[0]) | (rep_fire & i_btn_up)) ? onehot : '0;
            sub_d = ((press[0] & ~press[1]) | (rep_fire & i_btn_down)) ? onehot : '0;
            clear_d = press[1] & press[0];
            sel_d = press[2] ? ((o_sel == SEL_W'(N_FIELDS - 1)) ? '0 : o_sel + 1'b1) : o_sel;
            blink_cnt_d = (blink_cnt + 1'b1 == CNT_W'(BLINK_CYCLES)) ? '0 : blink_cnt + 1'b1;
            blink_d = (blink_cnt + 1'b1 == CNT_W'(BLINK_CYCLES)) ? ~o_blink : o_blink;
            to_cnt_d = (|press || rep_fire) ? '0 : to_cnt + 1'b1;
            if (to_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                state_d = RUN;
                sel_d = '0;
            end
        end
        if (state_d == RUN) begin
            blink_d = 1'b0;
            blink_cnt_d = '0;
            to_cnt_d = '0;
            rep_cnt_d = '0;
            rep_phase_d = 1'b0;
        end
    end

    // History resets high so a button held through reset release is not seen as a press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            o_sel <= '0;
            o_add <= '0;
            o_sub <= '0;
            o_clear <= 1'b0;
            o_blink <= 1'b0;
            rep_cnt <= '0;
            rep_phase <= 1'b0;
            to_cnt <= '0;
            blink_cnt <= '0;
            hist <= '1;
        end else begin
            state <= state_d;
            o_sel <= sel_d;
            o_add <= add_d;
            o_sub <= sub_d;
            o_clear <= clear_d;
            o_blink <= blink_d;
            rep_cnt <= rep_cnt_d;
            rep_phase <= rep_phase_d;
            to_cnt <= to_cnt_d;
            blink_cnt <= blink_cnt_d;
            hist <= btn;
        end
    end
endmodule
